serial_subtractor_18ec068: RTL and testbench

SERIAL_SUBTRACTOR_18EC068 -- requirements
Module: serial_subtractor_18ec068

---
 rtl/serial_subtractor_18ec068.sv | 106 ++++++++++
 tb/tb_serial_subtractor_18ec068.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_18ec068.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// over WIDTH cycles, then presents diff/borrow with a one-cycle done pulse.
module serial_subtractor_18ec068 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic ai, bi, d_bit, br_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    ai     = a_sh_q[0];
    bi     = b_sh_q[0];
    d_bit  = ai ^ bi ^ br_q;
    br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);

    case (state_q)
      SHIFT: begin
        // Result fills from the top so bit 0 has drifted down to position 0 at the end.
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        br_d   = br_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = br_nxt;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_18ec068.sv
// Self-checking bench for serial_subtractor_18ec068: directed vector table,
// hand-written multi-cycle corner cases, and a randomized run against a model.
module tb_serial_subtractor_18ec068;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int total;
  int bad;
  int excl_bad;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  vec_t vecs[7];

  serial_subtractor_18ec068 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be seen together outside reset
  always @(negedge clk) begin
    if (busy && done) excl_bad++;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full operation; returns at the negedge of the DONE cycle with start low.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise,
                               output logic [W-1:0] d_out, output logic br_out, output bit timing_ok);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start     = 1'b0;
    timing_ok = 1'b1;
    for (int j = 1; j <= W; j++) begin
      if (!(busy === 1'b1 && done === 1'b0)) timing_ok = 1'b0;
      if (noise) begin
        start = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!(done === 1'b1 && busy === 1'b0)) timing_ok = 1'b0;
    d_out  = diff;
    br_out = borrow;
  endtask

  logic [W-1:0] r_diff;
  logic         r_br;
  bit           t_ok;
  int           done_cnt;
  logic [W:0]   model;

  initial begin
    total    = 0;
    bad      = 0;
    excl_bad = 0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    rst_n    = 1'b0;

    vecs[0] = '{8'd5,  8'd3,  8'h02, 1'b0};
    vecs[1] = '{8'd3,  8'd5,  8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    vecs[5] = '{8'h0A, 8'h04, 8'h06, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset_busy",   32'(busy),   32'd0);
    checkOutput("reset_done",   32'(done),   32'd0);
    checkOutput("reset_diff",   32'(diff),   32'd0);
    checkOutput("reset_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b0, r_diff, r_br, t_ok);
      checkOutput($sformatf("vec%0d_timing", i), 32'(t_ok),   32'd1);
      checkOutput($sformatf("vec%0d_diff", i),   32'(r_diff), 32'(vecs[i].diff));
      checkOutput($sformatf("vec%0d_borrow", i), 32'(r_br),   32'(vecs[i].borrow));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
      checkOutput($sformatf("vec%0d_hold", i),       32'(diff), 32'(vecs[i].diff));
    end

    $display("[TB] start during SHIFT is ignored");
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    r_diff = '0;
    r_br = 1'b0;
    for (int c = 1; c <= W + 4; c++) begin
      if (c == 3) begin start = 1'b1; a = 8'h00; b = 8'h00; end
      if (c == 4) start = 1'b0;
      if (done) begin done_cnt++; r_diff = diff; r_br = borrow; end
      @(negedge clk);
    end
    checkOutput("ignore_done_count", 32'(done_cnt), 32'd1);
    checkOutput("ignore_diff",       32'(r_diff),   32'h7F);
    checkOutput("ignore_borrow",     32'(r_br),     32'd0);

    $display("[TB] back-to-back start in DONE cycle");
    applyStimulus(8'd5, 8'd3, 1'b0, r_diff, r_br, t_ok);
    checkOutput("b2b_first_diff", 32'(r_diff), 32'h02);
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55;
    checkOutput("b2b_busy_next", 32'(busy), 32'd1);
    checkOutput("b2b_hold_diff", 32'(diff), 32'h02);
    repeat (W) @(negedge clk);
    checkOutput("b2b_second_done",   32'(done),   32'd1);
    checkOutput("b2b_second_diff",   32'(diff),   32'hF0);
    checkOutput("b2b_second_borrow", 32'(borrow), 32'd1);

    $display("[TB] reset mid-SHIFT");
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #0.5;
    checkOutput("midrst_busy",   32'(busy),   32'd0);
    checkOutput("midrst_diff",   32'(diff),   32'd0);
    checkOutput("midrst_borrow", 32'(borrow), 32'd0);
    #0.5 rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(8'h0A, 8'h04, 1'b0, r_diff, r_br, t_ok);
    checkOutput("postrst_timing", 32'(t_ok),   32'd1);
    checkOutput("postrst_diff",   32'(r_diff), 32'h06);
    checkOutput("postrst_borrow", 32'(r_br),   32'd0);

    $display("[TB] randomized run");
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 10 == 0) ra = rb;
      model = {1'b0, ra} - {1'b0, rb};
      applyStimulus(ra, rb, 1'b1, r_diff, r_br, t_ok);
      checkOutput($sformatf("rand%0d_timing", n), 32'(t_ok),          32'd1);
      checkOutput($sformatf("rand%0d_result", n), 32'({r_br, r_diff}), 32'(model));
    end

    checkOutput("busy_done_exclusive", 32'(excl_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
